// File: rtl/zipo_mem_arbiter_pkg.sv
// Shared definitions for the zipo memory arbiter.
// Contents:
//   state_t  - sequencer FSM states (IDLE, ACCESS)
//   owner_t  - requester identity (OWN_IF = fetch, OWN_D = load/store)
//   RW_READ / RW_WRITE - mem_rw encodings
//   CNT_W    - width of the access latency counter
package zipo_mem_arbiter_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_t;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    localparam int CNT_W = 4;

endpackage

// File: rtl/zipo_rr_arbiter.sv
// Two-way round-robin picker (purely combinational).
// Ports:
//   req[1:0]   in  - request vector, bit 0 = fetch, bit 1 = data
//   last       in  - port granted most recently
//   grant[1:0] out - one-hot grant (all zero when nothing requests)
import zipo_mem_arbiter_pkg::*;

module zipo_rr_arbiter (
    input  logic [1:0] req,
    input  owner_t     last,
    output logic [1:0] grant
);

    always_comb begin
        grant = req;
        // On contention the port that did not win last time goes next.
        if (req == 2'b11) begin
            grant = (last == OWN_IF) ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/zipo_mem_arbiter.sv
// Arbiter and sequencer for the single 64-bit memory port shared by the
// instruction-fetch path and the load/store path.
// One access at a time: a grant in IDLE latches the bus registers, the bus is
// held for MEM_LATENCY cycles, then read data / completion is returned to the
// owning requester as a one-cycle registered rvalid pulse.
// Ports:
//   clk, rst                       - clock, asynchronous active-high reset
//   if_req/if_addr                 - fetch request (held until if_gnt)
//   if_gnt/if_rvalid/if_rdata      - fetch accept, completion pulse, word
//   d_req/d_we/d_addr/d_wdata      - data request (held until d_gnt)
//   d_gnt/d_rvalid/d_rdata         - data accept, completion pulse, load data
//   mem_rw/mem_addr/mem_write      - memory bus command (registered)
//   mem_read                       - memory read data, sampled on last cycle
// Handshake: a req is accepted in the cycle its gnt is high (combinational,
// IDLE only); the address/data are sampled on that same clock edge. A req
// still high afterwards is treated as a fresh request at the next IDLE.
import zipo_mem_arbiter_pkg::*;

module zipo_mem_arbiter #(
    parameter int MEM_LATENCY = 1,
    parameter int DATA_W      = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [DATA_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [DATA_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_rw,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_write,
    input  logic [DATA_W-1:0] mem_read
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

    state_t              state_q, state_d;
    owner_t              owner_q, owner_d;
    owner_t              last_q, last_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                mem_rw_q, mem_rw_d;
    logic [DATA_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_write_q, mem_write_d;
    logic                if_rvalid_q, if_rvalid_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
    logic                d_rvalid_q, d_rvalid_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;

    logic [1:0]          grant;

    zipo_rr_arbiter u_rr (
        .req   ({d_req, if_req}),
        .last  (last_q),
        .grant (grant)
    );

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        mem_rw_d    = mem_rw_q;
        mem_addr_d  = mem_addr_q;
        mem_write_d = mem_write_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        if_rvalid_d = 1'b0;
        d_rvalid_d  = 1'b0;
        if_gnt      = 1'b0;
        d_gnt       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if_gnt = grant[0];
                d_gnt  = grant[1];
                if (grant[1]) begin
                    owner_d    = OWN_D;
                    mem_addr_d = d_addr;
                    mem_rw_d   = d_we ? RW_WRITE : RW_READ;
                    if (d_we) begin
                        mem_write_d = d_wdata;
                    end
                end else if (grant[0]) begin
                    owner_d    = OWN_IF;
                    mem_addr_d = if_addr;
                    mem_rw_d   = RW_READ;
                end
                if (grant != 2'b00) begin
                    last_d  = owner_d;
                    cnt_d   = CNT_LOAD;
                    state_d = ST_ACCESS;
                end
            end

            ST_ACCESS: begin
                if (cnt_q == '0) begin
                    // mem_rw_q still tells a store from a load here; it is
                    // only dropped on this same edge.
                    if (owner_q == OWN_IF) begin
                        if_rdata_d  = mem_read;
                        if_rvalid_d = 1'b1;
                    end else begin
                        if (mem_rw_q == RW_READ) begin
                            d_rdata_d = mem_read;
                        end
                        d_rvalid_d = 1'b1;
                    end
                    mem_rw_d = RW_READ;
                    state_d  = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_IF;
            last_q      <= OWN_D;
            cnt_q       <= '0;
            mem_rw_q    <= RW_READ;
            mem_addr_q  <= '0;
            mem_write_q <= '0;
            if_rvalid_q <= 1'b0;
            if_rdata_q  <= '0;
            d_rvalid_q  <= 1'b0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            mem_rw_q    <= mem_rw_d;
            mem_addr_q  <= mem_addr_d;
            mem_write_q <= mem_write_d;
            if_rvalid_q <= if_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            d_rvalid_q  <= d_rvalid_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    assign if_rvalid = if_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign d_rvalid  = d_rvalid_q;
    assign d_rdata   = d_rdata_q;
    assign mem_rw    = mem_rw_q;
    assign mem_addr  = mem_addr_q;
    assign mem_write = mem_write_q;

endmodule

// File: tb/tb_zipo_mem_arbiter.sv
// Bench for zipo_mem_arbiter. Three instances (MEM_LATENCY 1, 3, 4) share the
// same stimulus; `sel` picks the instance a scenario is checking. Expected
// completions {port, data} are queued when a request is issued and popped by
// the monitor whenever the selected instance raises an rvalid.
module tb_zipo_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req;
    logic [63:0] if_addr;
    logic        d_req;
    logic        d_we;
    logic [63:0] d_addr;
    logic [63:0] d_wdata;
    logic [63:0] rd_data;

    logic        if_gnt_w    [3];
    logic        if_rvalid_w [3];
    logic [63:0] if_rdata_w  [3];
    logic        d_gnt_w     [3];
    logic        d_rvalid_w  [3];
    logic [63:0] d_rdata_w   [3];
    logic        mem_rw_w    [3];
    logic [63:0] mem_addr_w  [3];
    logic [63:0] mem_write_w [3];

    int sel = 0;

    logic        m_if_gnt, m_if_rvalid, m_d_gnt, m_d_rvalid, m_mem_rw;
    logic [63:0] m_if_rdata, m_d_rdata, m_mem_addr, m_mem_write;

    logic [64:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int LAT = (g == 0) ? 1 : (g == 1) ? 3 : 4;
        zipo_mem_arbiter #(.MEM_LATENCY(LAT), .DATA_W(64)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .if_req    (if_req),
            .if_addr   (if_addr),
            .if_gnt    (if_gnt_w[g]),
            .if_rvalid (if_rvalid_w[g]),
            .if_rdata  (if_rdata_w[g]),
            .d_req     (d_req),
            .d_we      (d_we),
            .d_addr    (d_addr),
            .d_wdata   (d_wdata),
            .d_gnt     (d_gnt_w[g]),
            .d_rvalid  (d_rvalid_w[g]),
            .d_rdata   (d_rdata_w[g]),
            .mem_rw    (mem_rw_w[g]),
            .mem_addr  (mem_addr_w[g]),
            .mem_write (mem_write_w[g]),
            .mem_read  (rd_data)
        );
    end

    assign m_if_gnt    = if_gnt_w[sel];
    assign m_if_rvalid = if_rvalid_w[sel];
    assign m_if_rdata  = if_rdata_w[sel];
    assign m_d_gnt     = d_gnt_w[sel];
    assign m_d_rvalid  = d_rvalid_w[sel];
    assign m_d_rdata   = d_rdata_w[sel];
    assign m_mem_rw    = mem_rw_w[sel];
    assign m_mem_addr  = mem_addr_w[sel];
    assign m_mem_write = mem_write_w[sel];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got === want) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
        end
    endtask

    task automatic pop_check(input logic port, input logic [63:0] data);
        logic [64:0] e;
        if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL unexpected rvalid: port %0d data 0x%0h, none expected", port, data);
        end else begin
            e = exp_q.pop_front();
            check("rvalid port", {63'd0, port}, {63'd0, e[64]});
            check("rdata", data, e[63:0]);
        end
    endtask

    // Monitor: every rvalid of the selected instance must match the queue head.
    always @(negedge clk) begin
        if (!rst) begin
            if (m_if_rvalid) pop_check(1'b0, m_if_rdata);
            if (m_d_rvalid)  pop_check(1'b1, m_d_rdata);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst    = 1'b1;
        if_req = 1'b0;
        d_req  = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic drain(input int cycles);
        repeat (cycles) tick();
        check("queue drained", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int grants;
        int cyc;
        int last_cyc;
        logic port;

        rst = 1'b1; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        if_addr = '0; d_addr = '0; d_wdata = '0; rd_data = '0;

        // Reset values.
        sel = 0;
        @(negedge clk);
        check("reset mem_rw",    {63'd0, m_mem_rw}, 64'd0);
        check("reset mem_addr",  m_mem_addr, 64'd0);
        check("reset mem_write", m_mem_write, 64'd0);
        check("reset if_rvalid", {63'd0, m_if_rvalid}, 64'd0);
        check("reset d_rvalid",  {63'd0, m_d_rvalid}, 64'd0);
        check("reset if_rdata",  m_if_rdata, 64'd0);
        check("reset d_rdata",   m_d_rdata, 64'd0);

        // Single fetch, latency 1.
        sel = 0;
        do_reset();
        tick();
        if_req = 1'b1; if_addr = 64'h40; rd_data = 64'h13;
        exp_q.push_back({1'b0, 64'h13});
        @(negedge clk);
        check("fetch if_gnt c0", {63'd0, m_if_gnt}, 64'd1);
        check("fetch d_gnt c0",  {63'd0, m_d_gnt}, 64'd0);
        tick();
        if_req = 1'b0;
        @(negedge clk);
        check("fetch mem_addr c1", m_mem_addr, 64'h40);
        check("fetch mem_rw c1",   {63'd0, m_mem_rw}, 64'd0);
        check("fetch if_gnt c1",   {63'd0, m_if_gnt}, 64'd0);
        drain(3);

        // Load then store, latency 3.
        sel = 1;
        do_reset();
        tick();
        d_req = 1'b1; d_we = 1'b0; d_addr = 64'h200; rd_data = 64'h77;
        exp_q.push_back({1'b1, 64'h77});
        @(negedge clk);
        check("load d_gnt", {63'd0, m_d_gnt}, 64'd1);
        tick();
        d_req = 1'b0;
        repeat (4) tick();
        d_req = 1'b1; d_we = 1'b1; d_addr = 64'h100; d_wdata = 64'hDEADBEEF; rd_data = 64'h99;
        exp_q.push_back({1'b1, 64'h77});
        @(negedge clk);
        check("store d_gnt", {63'd0, m_d_gnt}, 64'd1);
        for (int c = 1; c <= 3; c++) begin
            tick();
            d_req = 1'b0;
            @(negedge clk);
            check("store mem_rw",    {63'd0, m_mem_rw}, 64'd1);
            check("store mem_addr",  m_mem_addr, 64'h100);
            check("store mem_write", m_mem_write, 64'hDEADBEEF);
        end
        tick();
        @(negedge clk);
        check("store mem_rw c4", {63'd0, m_mem_rw}, 64'd0);
        drain(2);

        // Contention from reset, latency 1: F,D,F,D,... every 2 cycles.
        sel = 0;
        do_reset();
        tick();
        if_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
        if_addr = 64'h1000; d_addr = 64'h2000; rd_data = 64'hABC;
        grants = 0; cyc = 0; last_cyc = 0;
        while (grants < 8 && cyc < 40) begin
            @(negedge clk);
            if (m_if_gnt || m_d_gnt) begin
                port = m_d_gnt;
                check("grant order", {63'd0, port}, 64'(grants % 2));
                check("grant one-hot", {63'd0, m_if_gnt & m_d_gnt}, 64'd0);
                if (grants > 0) check("grant spacing", 64'(cyc - last_cyc), 64'd2);
                exp_q.push_back({port, 64'hABC});
                last_cyc = cyc;
                grants++;
            end
            tick();
            cyc++;
        end
        if_req = 1'b0; d_req = 1'b0;
        check("grant count", 64'(grants), 64'd8);
        drain(3);

        // Data request withdrawn during a fetch access.
        sel = 0;
        do_reset();
        tick();
        if_req = 1'b1; if_addr = 64'h80; rd_data = 64'h21;
        exp_q.push_back({1'b0, 64'h21});
        @(negedge clk);
        check("withdraw if_gnt", {63'd0, m_if_gnt}, 64'd1);
        tick();
        if_req = 1'b0; d_req = 1'b1; d_we = 1'b0; d_addr = 64'h500;
        @(negedge clk);
        check("withdraw d_gnt", {63'd0, m_d_gnt}, 64'd0);
        tick();
        d_req = 1'b0;
        drain(4);
        check("withdraw mem_addr", m_mem_addr, 64'h80);

        // Reset in cycle 2 of a latency-4 load.
        sel = 2;
        do_reset();
        tick();
        d_req = 1'b1; d_we = 1'b0; d_addr = 64'h300; rd_data = 64'h44;
        @(negedge clk);
        check("abort d_gnt", {63'd0, m_d_gnt}, 64'd1);
        tick();
        d_req = 1'b0;
        @(negedge clk);
        check("abort mem_addr c1", m_mem_addr, 64'h300);
        tick();
        rst = 1'b1;
        @(negedge clk);
        check("abort mem_rw",    {63'd0, m_mem_rw}, 64'd0);
        check("abort mem_addr",  m_mem_addr, 64'd0);
        check("abort mem_write", m_mem_write, 64'd0);
        check("abort d_rvalid",  {63'd0, m_d_rvalid}, 64'd0);
        check("abort d_rdata",   m_d_rdata, 64'd0);
        check("abort if_rvalid", {63'd0, m_if_rvalid}, 64'd0);
        tick();
        tick();
        rst = 1'b0;
        repeat (6) tick();
        if_req = 1'b1; d_req = 1'b1; if_addr = 64'h600;
        exp_q.push_back({1'b0, 64'h44});
        @(negedge clk);
        check("post-reset if_gnt", {63'd0, m_if_gnt}, 64'd1);
        check("post-reset d_gnt",  {63'd0, m_d_gnt}, 64'd0);
        tick();
        if_req = 1'b0; d_req = 1'b0;
        drain(6);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/zipo_mem_arbiter.md
# zipo_mem_arbiter

Two-requester arbiter and sequencer for the CPU's single 64-bit memory port (rw/addr/write/read). It sits between the core's instruction-fetch path and its load/store path and the memory. It grants one access at a time using round-robin, drives the memory bus for a parameterised fixed latency, and returns read data/completion to the owning requester.

## Interface
- MEM_LATENCY, 1, cycles from mem_addr valid to mem_read being sampled; legal 1..15
- DATA_W, 64, bus data and address width; fixed at 64
- clk  in  1  rising-edge clock
- rst  in  1  reset, asynchronous, active-high
- if_req  in  1  fetch request; held until if_gnt
- if_addr  in  64  fetch address; sampled on the grant edge
- if_gnt  out  1  fetch request accepted this cycle (combinational)
- if_rvalid  out  1  one-cycle pulse: if_rdata valid
- if_rdata  out  64  fetched word
- d_req  in  1  data request; held until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_addr  in  64  data address
- d_wdata  in  64  store data
- d_gnt  out  1  data request accepted this cycle (combinational)
- d_rvalid  out  1  one-cycle completion pulse (loads and stores)
- d_rdata  out  64  load data; unchanged on store completion
- mem_rw  out  1  1 = write, 0 = read
- mem_addr  out  64  memory address
- mem_write  out  64  memory write data
- mem_read  in  64  memory read data

## Operation
- FSM states: IDLE and ACCESS.
- IDLE: if exactly one req is high, grant it. If both are high, grant the one not granted last (round-robin pointer `last`). The gnt is asserted only in IDLE.
- On the grant edge the arbiter registers:
  - mem_addr <= owner addr
  - mem_rw <= (owner is data) & d_we
  - mem_write <= d_wdata for a store, else unchanged
  - owner <= granted port, last <= granted port
  - cnt <= MEM_LATENCY-1
  - state <= ACCESS
- ACCESS: cnt decrements each cycle. On the cycle where cnt==0:
  - owner rdata <= mem_read (loads and fetches only)
  - owner rvalid <= 1 for the next cycle
  - mem_rw <= 0
  - state <= IDLE
- rvalid is a registered pulse, exactly one cycle wide. The other port's rvalid stays 0.
- A req that drops before its gnt produces no access.
- A req still high after its gnt is a new request at the next IDLE.
- Both requests continuously high: grants alternate F, D, F, D, ...
- cnt is 4 bits wide. It never wraps because it reloads on every grant.

## Timing
- Reset values: state IDLE, mem_rw 0, mem_addr 0, mem_write 0, both rvalid 0, both rdata 0, cnt 0.
- Reset value of `last` is data, so fetch wins the first contention.
- Reset asserted mid-ACCESS aborts the access: no rvalid is produced and mem_rw drops to 0 immediately.
- Grant in cycle N puts mem_addr/mem_rw valid for cycles N+1 .. N+MEM_LATENCY.
- mem_read is sampled at the end of cycle N+MEM_LATENCY.
- rvalid is high in cycle N+MEM_LATENCY+1. That cycle is IDLE, so a new gnt may coincide with it.
- Gnt-to-rvalid latency is MEM_LATENCY+1. Peak throughput is one access per MEM_LATENCY+1 cycles.
- mem_rw is 1 only during ACCESS of a store. It is never high in IDLE.

## Structure
- Shared include (alongside the instruction constants): FSM state encodings, owner encoding (OWN_IF=0, OWN_D=1), and RW_READ/RW_WRITE.
- One sub-module, zipo_rr_arbiter: a 2-way round-robin picker.
  - Inputs: req[1:0], last.
  - Outputs: one-hot grant.
  - Purely combinational.
- The FSM, latency counter and bus registers stay in zipo_mem_arbiter.

## Test plan
- Single fetch: MEM_LATENCY=1, if_req with if_addr=0x40, memory returns 0x13 → if_gnt in cycle 0, mem_addr=0x40 and mem_rw=0 in cycle 1, if_rvalid=1 with if_rdata=0x13 in cycle 2, d_rvalid=0 throughout.
- Store: MEM_LATENCY=3, d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF → mem_rw=1, mem_addr=0x100, mem_write=0xDEADBEEF in cycles 1-3; d_rvalid pulse in cycle 4; mem_rw=0 from cycle 4; d_rdata unchanged.
- Contention from reset: both reqs held high for 8 grants with MEM_LATENCY=1 → grant order F,D,F,D,F,D,F,D; one grant every 2 cycles.
- Req withdrawn: d_req pulsed for one cycle during a fetch's ACCESS → no data access issued and no d_gnt.
- Reset mid-access: rst asserted in cycle 2 of a MEM_LATENCY=4 load → no d_rvalid; all outputs at reset values; first grant after release goes to fetch under contention.
